// File: rtl/avr_pkg.sv
// Shared constants for the AVR prefetch queue: default widths, two-word opcode
// patterns (LDS/STS/JMP/CALL) and the fetch FSM encoding.
package avr_pkg;

    localparam int PC_W_DEF = 16;

    localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
    localparam logic [15:0] LDS_MATCH      = 16'h9000;
    localparam logic [15:0] STS_MATCH      = 16'h9200;
    localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2
    } pfq_state_e;

    // True when w is the opcode word of an instruction that carries a K word.
    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & LDS_STS_MASK) == LDS_MATCH) ||
               ((w & LDS_STS_MASK) == STS_MATCH) ||
               ((w & JMP_CALL_MASK) == JMP_CALL_MATCH);
    endfunction

endpackage

// File: rtl/avr_pfq_fifo.sv
// Circular buffer of {word, pc} entries with 1- or 2-entry pop, flush, and
// combinational head / head+1 read ports.
module avr_pfq_fifo #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [15:0]            push_word,
    input  logic [PC_W-1:0]        push_pc,
    input  logic                   pop1,
    input  logic                   pop2,
    output logic [15:0]            head_word,
    output logic [PC_W-1:0]        head_pc,
    output logic [15:0]            next_word,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0]     word;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   pop_cnt;

    assign pop_cnt   = pop2 ? (AW+1)'(2) : {{AW{1'b0}}, pop1};
    assign head_word = mem[rd_ptr].word;
    assign head_pc   = mem[rd_ptr].pc;
    assign next_word = mem[rd_ptr + AW'(1)].word;

    // Storage is not reset; level gates every read of it.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{word: push_word, pc: push_pc};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + pop_cnt[AW-1:0];
            level  <= level + {{AW{1'b0}}, push} - pop_cnt;
        end
    end

endmodule

// File: rtl/avr_prefetch_queue.sv
// AVR instruction prefetch: streams ROM words into a queue and issues whole
// instructions to decode. Macro AVR_PFQ_TWO_WORD_EN enables 32-bit instruction pairing.
module avr_prefetch_queue
    import avr_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    output logic [PC_W-1:0]        prog_addr,
    output logic                   prog_rd,
    input  logic [15:0]            prog_data,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_addr,
    output logic [15:0]            instr,
    output logic [15:0]            instr_k,
    output logic [PC_W-1:0]        instr_pc,
    output logic                   instr_is32,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [$clog2(DEPTH):0] q_level
);

    localparam int LW = $clog2(DEPTH) + 1;

    pfq_state_e      state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] pend_pc;
    logic            rd_pend;
    logic            room;
    logic            head_two;
    logic            fire;
    logic [15:0]     head_word;
    logic [15:0]     next_word;
    logic [PC_W-1:0] head_pc;
    logic [LW-1:0]   level;

    // A read in flight already owns a slot, so count it against capacity.
    assign room      = (32'(level) + 32'(rd_pend)) < DEPTH;
    assign prog_rd   = ((state == S_RUN) || (state == S_REDIR)) && room;
    assign prog_addr = fetch_pc;

`ifdef AVR_PFQ_TWO_WORD_EN
    assign head_two = is_two_word(head_word);
`else
    assign head_two = 1'b0;
`endif

    assign instr_valid = (level != '0) && (!head_two || (level > LW'(1))) && !redirect;
    assign fire        = instr_valid && instr_ready;
    assign instr       = instr_valid ? head_word : '0;
    assign instr_pc    = instr_valid ? head_pc : '0;
    assign instr_is32  = instr_valid && head_two;
    assign instr_k     = (instr_valid && head_two) ? next_word : '0;
    assign q_level     = level;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_VEC;
            pend_pc  <= '0;
            rd_pend  <= 1'b0;
        end else if (redirect) begin
            // Dropping rd_pend discards the word that lands next cycle.
            state    <= S_REDIR;
            fetch_pc <= redirect_addr;
            rd_pend  <= 1'b0;
        end else begin
            case (state)
                S_BOOT, S_REDIR, S_RUN: state <= S_RUN;
                default:                state <= S_BOOT;
            endcase
            rd_pend <= prog_rd;
            if (prog_rd) begin
                pend_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + PC_W'(1);
            end
        end
    end

    avr_pfq_fifo #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .flush     (redirect),
        .push      (rd_pend),
        .push_word (prog_data),
        .push_pc   (pend_pc),
        .pop1      (fire && !head_two),
        .pop2      (fire && head_two),
        .head_word (head_word),
        .head_pc   (head_pc),
        .next_word (next_word),
        .level     (level)
    );

endmodule

// File: tb/tb_avr_prefetch_queue.sv
// Bench for avr_prefetch_queue: directed cycle table, hand sequences for redirect,
// two-word and wrap corners, then random traffic against an instruction-stream model.
module tb_avr_prefetch_queue;

    localparam int PC_W  = 16;
    localparam int DEPTH = 4;
`ifdef AVR_PFQ_TWO_WORD_EN
    localparam bit TWO_WORD = 1'b1;
`else
    localparam bit TWO_WORD = 1'b0;
`endif

    logic                   CLK = 1'b0;
    logic                   RST = 1'b0;
    logic [PC_W-1:0]        prog_addr;
    logic                   prog_rd;
    logic [15:0]            prog_data = '0;
    logic                   redirect = 1'b0;
    logic [PC_W-1:0]        redirect_addr = '0;
    logic [15:0]            instr;
    logic [15:0]            instr_k;
    logic [PC_W-1:0]        instr_pc;
    logic                   instr_is32;
    logic                   instr_valid;
    logic                   instr_ready = 1'b0;
    logic [$clog2(DEPTH):0] q_level;

    logic [15:0]     rom [0:(1<<PC_W)-1];
    int              checks = 0;
    int              errors = 0;
    bit              mdl_on = 1'b0;
    logic [PC_W-1:0] exp_pc = '0;
    int              idle = 0;

    typedef struct {
        bit          rdy;
        bit          rd;
        logic [15:0] addr;
        bit          vld;
        logic [15:0] ins;
        logic [15:0] pc;
        int          lvl;
    } vec_t;

    vec_t tbl [18];

    avr_prefetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .prog_addr     (prog_addr),
        .prog_rd       (prog_rd),
        .prog_data     (prog_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr         (instr),
        .instr_k       (instr_k),
        .instr_pc      (instr_pc),
        .instr_is32    (instr_is32),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .q_level       (q_level)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (prog_rd) prog_data <= rom[prog_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit two_word(input logic [15:0] w);
        return TWO_WORD && (((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFC0F) == 16'h9200) ||
                            ((w & 16'hFE0C) == 16'h940C));
    endfunction

    function automatic logic [15:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        case (r[31:30])
            2'd0:    return 16'h9000 | (r[15:0] & 16'h03F0);
            2'd1:    return 16'h940C | (r[15:0] & 16'h01F3);
            default: return r[15:0];
        endcase
    endfunction

    // Stream model: the decoder should see the ROM parsed sequentially from the
    // last redirect target, one or two words per instruction.
    task automatic step();
        logic [15:0] w;
        bit          t;
        if (mdl_on) begin
            if (redirect) begin
                exp_pc = redirect_addr;
                idle   = 0;
            end else if (instr_valid && instr_ready) begin
                w = rom[exp_pc];
                t = two_word(w);
                chk("stream_instr", instr, w);
                chk("stream_pc", instr_pc, exp_pc);
                chk("stream_is32", instr_is32, t);
                chk("stream_k", instr_k, t ? rom[exp_pc + 16'd1] : 16'h0);
                exp_pc = exp_pc + (t ? 16'd2 : 16'd1);
                idle   = 0;
            end else if (instr_ready) begin
                idle++;
                if (idle > 8) begin
                    chk("starve", idle, 0);
                    idle = 0;
                end
            end
            if (q_level > DEPTH) chk("level_bound", q_level, DEPTH);
        end
        @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, prog_rd, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_k"}, instr_k, 0);
        chk({tag, "_pc"}, instr_pc, 0);
        chk({tag, "_is32"}, instr_is32, 0);
        chk({tag, "_level"}, q_level, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) rom[i] = rand_word();
        rom[0] = 16'hE0A4; rom[1] = 16'h50A1; rom[2] = 16'h0000; rom[3] = 16'h0000;
        rom[4] = 16'h0000; rom[5] = 16'h940C; rom[6] = 16'h0123; rom[7] = 16'h1234;
        rom[16'h20] = 16'h940C; rom[16'h21] = 16'h5555;
        rom[16'h40] = 16'h0777; rom[16'hFFFF] = 16'h1111;

        tbl[0]  = '{1'b1, 1'b0, 16'h0, 1'b0, 16'h0,    16'h0, 0};
        tbl[1]  = '{1'b1, 1'b1, 16'h0, 1'b0, 16'h0,    16'h0, 0};
        tbl[2]  = '{1'b1, 1'b1, 16'h1, 1'b0, 16'h0,    16'h0, 0};
        tbl[3]  = '{1'b1, 1'b1, 16'h2, 1'b1, 16'hE0A4, 16'h0, 1};
        tbl[4]  = '{1'b1, 1'b1, 16'h3, 1'b1, 16'h50A1, 16'h1, 1};
        tbl[5]  = '{1'b1, 1'b1, 16'h4, 1'b1, 16'h0000, 16'h2, 1};
        tbl[6]  = '{1'b0, 1'b1, 16'h5, 1'b1, 16'h0000, 16'h3, 1};
        tbl[7]  = '{1'b0, 1'b1, 16'h6, 1'b1, 16'h0000, 16'h3, 2};
        tbl[8]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'h3, 3};
        for (int i = 9; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'h3, 4};
        tbl[16] = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h0000, 16'h3, 4};
        tbl[17] = '{1'b1, 1'b1, 16'h7, 1'b1, 16'h0000, 16'h4, 3};

        @(negedge CLK);
        #1 chk_all_zero("reset");

        RST = 1'b1; mdl_on = 1'b1; exp_pc = '0; idle = 0;
        for (int i = 0; i < 18; i++) begin
            instr_ready = tbl[i].rdy;
            #1;
            chk($sformatf("t%0d_rd", i), prog_rd, tbl[i].rd);
            if (tbl[i].rd) chk($sformatf("t%0d_addr", i), prog_addr, tbl[i].addr);
            chk($sformatf("t%0d_valid", i), instr_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk($sformatf("t%0d_instr", i), instr, tbl[i].ins);
                chk($sformatf("t%0d_pc", i), instr_pc, tbl[i].pc);
            end
            chk($sformatf("t%0d_level", i), q_level, tbl[i].lvl);
            step();
        end

        // JMP at pc5 with K word 0123 already queued
        #1;
        chk("jmp_valid", instr_valid, 1);
        chk("jmp_instr", instr, 16'h940C);
        chk("jmp_pc", instr_pc, 5);
        chk("jmp_is32", instr_is32, TWO_WORD);
        chk("jmp_k", instr_k, TWO_WORD ? 16'h0123 : 16'h0);
        step();
        #1;
        chk("after_jmp_pc", instr_pc, TWO_WORD ? 7 : 6);
        chk("pend_pre_redir", prog_rd, 1);
        step();

        // Redirect with a read in flight
        redirect = 1'b1; redirect_addr = 16'h0040;
        #1 chk("redir_t0_valid", instr_valid, 0);
        step();
        redirect = 1'b0;
        #1;
        chk("redir_t1_rd", prog_rd, 1);
        chk("redir_t1_addr", prog_addr, 16'h0040);
        chk("redir_t1_level", q_level, 0);
        chk("redir_t1_valid", instr_valid, 0);
        step();
        #1;
        chk("redir_t2_valid", instr_valid, 0);
        chk("redir_t2_addr", prog_addr, 16'h0041);
        step();
        #1;
        chk("redir_t3_valid", instr_valid, 1);
        chk("redir_t3_instr", instr, 16'h0777);
        chk("redir_t3_pc", instr_pc, 16'h0040);
        step();

        // JMP opcode alone in the queue must wait for its K word
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_addr = 16'h0020;
        #1 step();
        redirect = 1'b0;
        #1 step();
        #1 step();
        #1;
        chk("half_jmp_level", q_level, 1);
        chk("half_jmp_valid", instr_valid, !TWO_WORD);
        step();
        #1;
        chk("full_jmp_valid", instr_valid, 1);
        chk("full_jmp_instr", instr, 16'h940C);
        chk("full_jmp_is32", instr_is32, TWO_WORD);
        chk("full_jmp_k", instr_k, TWO_WORD ? 16'h5555 : 16'h0);
        instr_ready = 1'b1;
        step();

        // Back-to-back redirects: the newer target wins
        redirect = 1'b1; redirect_addr = 16'h0100;
        #1 step();
        redirect_addr = 16'h0200;
        #1 step();
        redirect = 1'b0;
        #1;
        chk("reredir_addr", prog_addr, 16'h0200);
        chk("reredir_rd", prog_rd, 1);
        step();
        for (int i = 0; i < 6; i++) begin
            #1 step();
        end

        // Fetch PC wrap
        redirect = 1'b1; redirect_addr = 16'hFFFF;
        #1 step();
        redirect = 1'b0;
        #1;
        chk("wrap_t1_addr", prog_addr, 16'hFFFF);
        step();
        #1;
        chk("wrap_t2_addr", prog_addr, 16'h0000);
        chk("wrap_t2_rd", prog_rd, 1);
        step();
        #1;
        chk("wrap_t3_pc", instr_pc, 16'hFFFF);
        step();
        #1;
        chk("wrap_t4_pc", instr_pc, 16'h0000);
        chk("wrap_t4_rd", prog_rd, 1);

        // Reset mid-stream with a ROM return outstanding
        mdl_on = 1'b0;
        RST = 1'b0;
        step();
        #1 chk_all_zero("midrst");
        RST = 1'b1; mdl_on = 1'b1; exp_pc = '0; idle = 0;
        #1;
        chk("boot_rd", prog_rd, 0);
        step();
        #1;
        chk("boot_level", q_level, 0);
        chk("first_rd", prog_rd, 1);
        chk("first_addr", prog_addr, 16'h0000);
        step();

        for (int i = 0; i < 3000; i++) begin
            instr_ready   = ($urandom_range(0, 3) != 0);
            redirect      = ($urandom_range(0, 40) == 0);
            redirect_addr = 16'($urandom);
            #1 step();
        end
        redirect = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
